// File: rtl/mms_pkg.sv
// mms_pkg: shared defaults, FSM state codes and select encoding for the max/min group accumulator
package mms_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_GROUP  = 4;
    typedef logic [0:0] state_t;
    localparam state_t ACCUM = 1'b0;
    localparam state_t HOLD  = 1'b1;
    localparam logic SEL_MAX = 1'b0;
    localparam logic SEL_MIN = 1'b1;
endpackage

// File: rtl/mms_group_acc_cmp.sv
// mms_cmp: unsigned two-input max/min select; ties keep a so the earlier element wins
module mms_cmp
    import mms_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] win,
    output logic         take_b
);
    // strict compare so equal values never displace the running winner
    always_comb begin
        take_b = (sel == SEL_MIN) ? (b < a) : (b > a);
        win    = take_b ? b : a;
    end
endmodule

// File: rtl/mms_group_acc.sv
// mms_group_acc: serial valid/ready front-end that reduces GROUP numbers to their max or min
// Optional winner-index output enabled by defining MMS_INDEX_EN.
module mms_group_acc
    import mms_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int GROUP  = DEF_GROUP,
    parameter int CNT_W  = $clog2(GROUP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_select,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
`ifdef MMS_INDEX_EN
    ,
    output logic [CNT_W-1:0]  out_index
`endif
);
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic              sel_q;
    logic [DATA_W-1:0] win;
    logic              take_b;
    logic              in_acc;
    logic              last;
`ifdef MMS_INDEX_EN
    logic [CNT_W-1:0]  idx;
`endif

    mms_cmp #(.W(DATA_W)) u_cmp (
        .a      (acc),
        .b      (in_data),
        .sel    (sel_q),
        .win    (win),
        .take_b (take_b)
    );

    // handshake flags come straight from the state register
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        in_acc    = in_valid & in_ready;
        last      = (cnt == CNT_W'(GROUP - 1));
    end

    // accumulate the group, then hold the result until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
            sel_q <= SEL_MAX;
`ifdef MMS_INDEX_EN
            idx   <= '0;
`endif
        end else if (in_acc) begin
            if (cnt == '0) begin
                acc   <= in_data;
                sel_q <= in_select;
`ifdef MMS_INDEX_EN
                idx   <= '0;
`endif
            end else begin
                acc <= win;
`ifdef MMS_INDEX_EN
                if (take_b) idx <= cnt;
`endif
            end
            cnt   <= last ? '0 : cnt + 1'b1;
            state <= last ? HOLD : ACCUM;
        end else if (out_valid && out_ready) begin
            state <= ACCUM;
        end
    end

    assign out_result = acc;
`ifdef MMS_INDEX_EN
    assign out_index = idx;
`endif
endmodule

// File: tb/tb_mms_group_acc.sv
// tb_mms_group_acc: directed self-checking bench for mms_group_acc (index checks need MMS_INDEX_EN)
module tb_mms_group_acc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_select = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_result;
`ifdef MMS_INDEX_EN
    logic [1:0] out_index;
`endif
    int checks = 0;
    int errors = 0;

    mms_group_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_select  (in_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef MMS_INDEX_EN
        ,
        .out_index  (out_index)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one element and wait (bounded) until it has been accepted
    task automatic push(input logic [7:0] d, input logic s);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_select = s;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push4(input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) push(d[8*i +: 8], s[i]);
    endtask

    // result must be presented now and, with out_ready high, gone one cycle later
    task automatic expect_result(input string tag, input logic [7:0] r, input logic [1:0] ix);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_result"}, {24'd0, out_result}, {24'd0, r});
`ifdef MMS_INDEX_EN
        chk({tag, "_index"}, {30'd0, out_index}, {30'd0, ix});
`else
        if (ix != 2'd0) checks += 0;
`endif
        tick();
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [7:0] rd [12];
    logic       rs [3];
    logic [7:0] mr [3];
    logic [1:0] mi [3];

    initial begin
        // reset values
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", {24'd0, out_result}, 32'd0);
`ifdef MMS_INDEX_EN
        chk("rst_out_index", {30'd0, out_index}, 32'd0);
`endif
        #20;
        rst_n = 1'b1;
        tick();

        // max of a plain group; in_ready low for exactly one cycle
        push4(32'h7F05_8012, 4'b0000);
        expect_result("max", 8'h80, 2'd1);

        // min selected on the first element; later toggles ignored
        push4(32'h7F05_8012, 4'b0101);
        expect_result("min_toggle", 8'h05, 2'd2);

        // ties keep the earliest element
        push4(32'h3310_3333, 4'b0000);
        expect_result("tie_max", 8'h33, 2'd0);
        push4(32'h00FF_FF00, 4'b1111);
        expect_result("bound_min", 8'h00, 2'd0);

        // backpressure: result stable, 0xAA held off until the result transfers
        out_ready = 1'b0;
        push4(32'h7F05_8012, 4'b0000);
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        in_select = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", {24'd0, out_result}, 32'h80);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_transfer", {31'd0, out_valid}, 32'd0);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        expect_result("bp_next", 8'hAA, 2'd0);

        // reset mid-group discards the partial group
        push(8'h50, 1'b0);
        push(8'h60, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result", {24'd0, out_result}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        #20;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        push4(32'h0403_0201, 4'b0000);
        expect_result("post_rst", 8'h04, 2'd3);
        chk("post_rst_single", {31'd0, out_valid}, 32'd0);

        // back-to-back random groups checked against a max/min model
        for (int g = 0; g < 3; g++) begin
            rs[g] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) rd[4*g+i] = 8'($urandom_range(0, 255));
            mr[g] = rd[4*g];
            mi[g] = 2'd0;
            for (int i = 1; i < 4; i++)
                if (rs[g] ? (rd[4*g+i] < mr[g]) : (rd[4*g+i] > mr[g])) begin
                    mr[g] = rd[4*g+i];
                    mi[g] = 2'(i);
                end
        end
        begin
            int k = 0;
            int g = 0;
            int last = 0;
            logic acc_now;
            for (int c = 0; c < 40 && g < 3; c++) begin
                in_valid  = (k < 12);
                in_data   = (k < 12) ? rd[k] : 8'h00;
                in_select = (k < 12) ? rs[k/4] : 1'b0;
                acc_now   = in_valid & in_ready;
                tick();
                if (acc_now) k++;
                if (out_valid) begin
                    chk("b2b_result", {24'd0, out_result}, {24'd0, mr[g]});
`ifdef MMS_INDEX_EN
                    chk("b2b_index", {30'd0, out_index}, {30'd0, mi[g]});
`endif
                    if (g > 0) chk("b2b_spacing", 32'(c - last), 32'd5);
                    last = c;
                    g++;
                end
            end
            in_valid = 1'b0;
            chk("b2b_groups", 32'(g), 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
